// File: rtl/done_responder_pkg.sv
// Shared types and defaults for the host-side done responder.
// Contents:
//   responder_state            - states of the responder FSM
//   done_state                 - states of the AFU-side done controller
//   ResponseStatistcsInterface - statistics bundle that travels with a report
//   SOFT_RESET_CYCLES_DEFAULT / REPORT_TIMEOUT_CYCLES_DEFAULT
//   status_present()           - true when a status word carries a report
package done_responder_pkg;

    localparam int SOFT_RESET_CYCLES_DEFAULT     = 8;
    localparam int REPORT_TIMEOUT_CYCLES_DEFAULT = 1024;

    typedef enum logic [2:0] {
        RSP_RESET,
        RSP_IDLE,
        RSP_SOFT_RESET,
        RSP_WAIT_REPORT,
        RSP_ACK,
        RSP_DRAIN
    } responder_state;

    typedef enum logic [1:0] {
        DONE_IDLE,
        DONE_SOFT_RESET,
        DONE_REPORT,
        DONE_WAIT_ACK
    } done_state;

    typedef struct packed {
        logic [31:0] read_responses;
        logic [31:0] write_responses;
    } ResponseStatistcsInterface;

    // The algorithm always finishes with a nonzero status, so zero means
    // "nothing presented".
    function automatic logic status_present(input logic [0:63] status);
        return |status;
    endfunction

endpackage

// File: rtl/done_report_capture.sv
// Capture registers for the report handed over by the done controller.
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   capture_i       - load status/statistics this cycle
//   timeout_set_i   - set the sticky report-timeout flag
//   read_i          - host has read the status; clears valid/overflow/timeout
//   status_i/stats_i- report being presented
//   status_o/stats_o- captured report (kept across host reads)
//   valid_o         - captured report not yet read
//   overflow_o      - sticky: a report was overwritten before being read
//   timeout_o       - sticky: a report did not arrive in time
module done_report_capture
    import done_responder_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      capture_i,
    input  logic                      timeout_set_i,
    input  logic                      read_i,
    input  logic [0:63]               status_i,
    input  ResponseStatistcsInterface stats_i,
    output logic [0:63]               status_o,
    output ResponseStatistcsInterface stats_o,
    output logic                      valid_o,
    output logic                      overflow_o,
    output logic                      timeout_o
);

    logic [0:63]               status_q;
    ResponseStatistcsInterface stats_q;
    logic                      valid_q, valid_d;
    logic                      overflow_q, overflow_d;
    logic                      timeout_q, timeout_d;

    // A capture beats a simultaneous read: the new report stays valid, and
    // because the read consumed the old one it is not counted as overwritten.
    always_comb begin
        valid_d    = valid_q;
        overflow_d = overflow_q;
        timeout_d  = timeout_q;
        if (read_i) begin
            valid_d    = 1'b0;
            overflow_d = 1'b0;
            timeout_d  = 1'b0;
        end
        if (capture_i) begin
            valid_d = 1'b1;
            if (valid_q && !read_i) begin
                overflow_d = 1'b1;
            end
        end
        if (timeout_set_i) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status_q   <= '0;
            stats_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (capture_i) begin
                status_q <= status_i;
                stats_q  <= stats_i;
            end
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    assign status_o   = status_q;
    assign stats_o    = stats_q;
    assign valid_o    = valid_q;
    assign overflow_o = overflow_q;
    assign timeout_o  = timeout_q;

endmodule

// File: rtl/done_responder.sv
// Host-facing partner of the AFU done controller. Answers a soft-reset
// request (falling edge on reset_done) with a timed soft_rstn pulse, then
// waits for the controller's report, captures it for MMIO and acknowledges.
// Ports:
//   clock, rstn                  - clock, asynchronous active-low reset
//   enabled_in                   - AFU enable (registered before use)
//   reset_done                   - 1->0 transition requests a soft reset
//   report_algorithm_status      - nonzero when a report is presented
//   report_response_statistics   - statistics accompanying the report
//   mmio_status_read             - host read pulse
//   soft_rstn                    - active-low soft reset to the datapath
//   report_algorithm_status_ack  - one-cycle acknowledge of a capture
//   mmio_*                       - captured report and sticky flags
//   responder_busy               - FSM is not idle
module done_responder
    import done_responder_pkg::*;
#(
    parameter int SOFT_RESET_CYCLES     = SOFT_RESET_CYCLES_DEFAULT,
    parameter int REPORT_TIMEOUT_CYCLES = REPORT_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                      clock,
    input  logic                      rstn,
    input  logic                      enabled_in,
    input  logic                      reset_done,
    input  logic [0:63]               report_algorithm_status,
    input  ResponseStatistcsInterface report_response_statistics,
    input  logic                      mmio_status_read,
    output logic                      soft_rstn,
    output logic                      report_algorithm_status_ack,
    output logic [0:63]               mmio_algorithm_status,
    output ResponseStatistcsInterface mmio_response_statistics,
    output logic                      mmio_status_valid,
    output logic                      mmio_status_overflow,
    output logic                      mmio_report_timeout,
    output logic                      responder_busy
);

    localparam logic [7:0]  SOFT_LOAD       = 8'(SOFT_RESET_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST    = 32'(REPORT_TIMEOUT_CYCLES - 1);
    localparam logic        TIMEOUT_ENABLED = (REPORT_TIMEOUT_CYCLES != 0);

    logic           enabled_q;
    logic           reset_done_q;
    logic           reset_done_prev_q;
    logic           pending_q;
    responder_state state_q;
    logic [7:0]     soft_count_q;
    logic [31:0]    wait_count_q;
    logic           soft_rstn_q;
    logic           ack_q;

    logic request_edge;
    logic report_present;
    logic capture;
    logic timeout_hit;

    assign request_edge   = reset_done_prev_q & ~reset_done_q;
    assign report_present = status_present(report_algorithm_status);
    assign capture        = enabled_q && (state_q == RSP_WAIT_REPORT) && report_present;
    assign timeout_hit    = TIMEOUT_ENABLED && enabled_q && (state_q == RSP_WAIT_REPORT)
                            && !report_present && (wait_count_q == TIMEOUT_LAST);

    // Edge registers reset to 1 so that leaving reset with reset_done high
    // does not look like a request.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            enabled_q         <= 1'b0;
            reset_done_q      <= 1'b1;
            reset_done_prev_q <= 1'b1;
        end else begin
            enabled_q         <= enabled_in;
            reset_done_q      <= reset_done;
            reset_done_prev_q <= reset_done_q;
        end
    end

    // Responder FSM. The request edge is recorded in pending_q whatever the
    // enable, so a request made while disabled is serviced once enabled.
    // The ack is cleared every cycle so it stays a single-cycle pulse even
    // if the enable drops while in RSP_ACK.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q      <= RSP_RESET;
            pending_q    <= 1'b0;
            soft_count_q <= '0;
            wait_count_q <= '0;
            soft_rstn_q  <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            if (enabled_q) begin
                case (state_q)
                    RSP_RESET: begin
                        state_q     <= RSP_IDLE;
                        soft_rstn_q <= 1'b1;
                    end
                    RSP_IDLE: begin
                        if (pending_q) begin
                            state_q      <= RSP_SOFT_RESET;
                            pending_q    <= 1'b0;
                            soft_rstn_q  <= 1'b0;
                            soft_count_q <= SOFT_LOAD;
                        end
                    end
                    RSP_SOFT_RESET: begin
                        if (soft_count_q == 8'd0) begin
                            state_q      <= RSP_WAIT_REPORT;
                            soft_rstn_q  <= 1'b1;
                            wait_count_q <= '0;
                        end else begin
                            soft_count_q <= soft_count_q - 8'd1;
                        end
                    end
                    RSP_WAIT_REPORT: begin
                        if (capture) begin
                            state_q <= RSP_ACK;
                            ack_q   <= 1'b1;
                        end else if (timeout_hit) begin
                            state_q <= RSP_IDLE;
                        end else if (TIMEOUT_ENABLED) begin
                            wait_count_q <= wait_count_q + 32'd1;
                        end
                    end
                    RSP_ACK: begin
                        state_q <= RSP_DRAIN;
                    end
                    RSP_DRAIN: begin
                        // The controller holds its report briefly after the
                        // ack; waiting for zero avoids capturing it twice.
                        if (!report_present) begin
                            state_q <= RSP_IDLE;
                        end
                    end
                    default: begin
                        state_q <= RSP_RESET;
                    end
                endcase
            end
            if (request_edge) begin
                pending_q <= 1'b1;
            end
        end
    end

    done_report_capture u_capture (
        .clk_i         (clock),
        .rst_ni        (rstn),
        .capture_i     (capture),
        .timeout_set_i (timeout_hit),
        .read_i        (mmio_status_read),
        .status_i      (report_algorithm_status),
        .stats_i       (report_response_statistics),
        .status_o      (mmio_algorithm_status),
        .stats_o       (mmio_response_statistics),
        .valid_o       (mmio_status_valid),
        .overflow_o    (mmio_status_overflow),
        .timeout_o     (mmio_report_timeout)
    );

    assign soft_rstn                   = soft_rstn_q;
    assign report_algorithm_status_ack = ack_q;
    assign responder_busy              = (state_q != RSP_IDLE);

endmodule

// File: tb/tb_done_responder.sv
// Scoreboard bench for done_responder. Stimulus pushes the expected events
// (soft reset pulse length, captured report, timeout delay) into a queue;
// a monitor on the falling clock edge pops and compares as the DUT shows
// each event.
module tb_done_responder;
    import done_responder_pkg::*;

    localparam int SOFT_CYCLES    = 8;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int EV_SOFT        = 0;
    localparam int EV_REPORT      = 1;
    localparam int EV_TIMEOUT     = 2;

    typedef struct {
        int          kind;
        logic [63:0] status;
        logic [63:0] stats;
        logic        overflow;
        int          value;
    } expect_t;

    logic                      clock = 1'b0;
    logic                      rstn = 1'b0;
    logic                      enabled_in = 1'b0;
    logic                      reset_done = 1'b1;
    logic [0:63]               report_algorithm_status = '0;
    ResponseStatistcsInterface report_response_statistics = '0;
    logic                      mmio_status_read = 1'b0;
    logic                      soft_rstn;
    logic                      report_algorithm_status_ack;
    logic [0:63]               mmio_algorithm_status;
    ResponseStatistcsInterface mmio_response_statistics;
    logic                      mmio_status_valid;
    logic                      mmio_status_overflow;
    logic                      mmio_report_timeout;
    logic                      responder_busy;

    expect_t expQ[$];
    int      checksTotal = 0;
    int      checksPassed = 0;

    done_responder #(
        .SOFT_RESET_CYCLES     (SOFT_CYCLES),
        .REPORT_TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock                       (clock),
        .rstn                        (rstn),
        .enabled_in                  (enabled_in),
        .reset_done                  (reset_done),
        .report_algorithm_status     (report_algorithm_status),
        .report_response_statistics  (report_response_statistics),
        .mmio_status_read            (mmio_status_read),
        .soft_rstn                   (soft_rstn),
        .report_algorithm_status_ack (report_algorithm_status_ack),
        .mmio_algorithm_status       (mmio_algorithm_status),
        .mmio_response_statistics    (mmio_response_statistics),
        .mmio_status_valid           (mmio_status_valid),
        .mmio_status_overflow        (mmio_status_overflow),
        .mmio_report_timeout         (mmio_report_timeout),
        .responder_busy              (responder_busy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checksTotal++;
        $display("[TB] FAIL %s: wait bound expired, expected event did not occur", name);
    endtask

    task automatic popExpect(input int kind, output expect_t e, output bit ok);
        ok = 1'b0;
        e  = '{kind: -1, status: '0, stats: '0, overflow: 1'b0, value: 0};
        if (expQ.size() == 0) begin
            checksTotal++;
            $display("[TB] FAIL unexpectedEvent: got event kind %0d, expected none", kind);
        end else begin
            e = expQ.pop_front();
            checkOutput("eventKind", kind, e.kind);
            ok = (e.kind == kind);
        end
    endtask

    // Monitor: measures soft_rstn low runs, the time from soft_rstn release
    // to a timeout flag, and checks each captured report at its ack.
    int   lowRun = 0;
    int   sinceRelease = -1;
    logic fromReset = 1'b1;
    logic prevAck = 1'b0;
    logic prevTimeout = 1'b0;

    always @(negedge clock) begin
        expect_t e;
        bit      ok;
        if (!rstn) begin
            lowRun       = 0;
            sinceRelease = -1;
            fromReset    = 1'b1;
            prevAck      = 1'b0;
            prevTimeout  = 1'b0;
        end else begin
            if (sinceRelease >= 0) sinceRelease++;
            if (!soft_rstn) begin
                lowRun++;
            end else if (lowRun > 0) begin
                if (fromReset) begin
                    fromReset    = 1'b0;
                    sinceRelease = -1;
                end else begin
                    popExpect(EV_SOFT, e, ok);
                    if (ok) checkOutput("softRstnLowCycles", lowRun, e.value);
                    sinceRelease = 0;
                end
                lowRun = 0;
            end
            if (report_algorithm_status_ack) begin
                checkOutput("ackSingleCycle", prevAck, 1'b0);
                if (!prevAck) begin
                    popExpect(EV_REPORT, e, ok);
                    if (ok) begin
                        checkOutput("reportStatus", mmio_algorithm_status, e.status);
                        checkOutput("reportStats", mmio_response_statistics, e.stats);
                        checkOutput("reportValid", mmio_status_valid, 1'b1);
                        checkOutput("reportOverflow", mmio_status_overflow, e.overflow);
                    end
                end
            end
            if (mmio_report_timeout && !prevTimeout) begin
                popExpect(EV_TIMEOUT, e, ok);
                if (ok) checkOutput("timeoutDelay", sinceRelease, e.value);
            end
            prevAck     = report_algorithm_status_ack;
            prevTimeout = mmio_report_timeout;
        end
    end

    task automatic pushSoft();
        expQ.push_back('{kind: EV_SOFT, status: '0, stats: '0, overflow: 1'b0, value: SOFT_CYCLES});
    endtask

    task automatic pushReport(input logic [63:0] status, input logic [63:0] stats,
                              input logic overflow);
        expQ.push_back('{kind: EV_REPORT, status: status, stats: stats, overflow: overflow, value: 0});
    endtask

    task automatic pulseRequest();
        @(posedge clock); #1 reset_done = 1'b0;
        @(posedge clock); #1 reset_done = 1'b1;
    endtask

    task automatic hostRead();
        @(posedge clock); #1 mmio_status_read = 1'b1;
        @(posedge clock); #1 mmio_status_read = 1'b0;
        @(negedge clock);
    endtask

    task automatic waitIdle(input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (!responder_busy) return;
        end
        timeoutFail(name);
    endtask

    task automatic waitSoftRelease(output bit ok);
        bit seenLow;
        ok      = 1'b0;
        seenLow = !soft_rstn;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (!soft_rstn) begin
                seenLow = 1'b1;
            end else if (seenLow) begin
                ok = 1'b1;
                return;
            end
        end
        timeoutFail("softRstnPulse");
    endtask

    // Waits for the soft reset to end, presents a report, waits for the ack
    // and clears the report two cycles later, as the done controller does.
    task automatic completeFlow(input logic [63:0] status, input logic [63:0] stats);
        bit ok;
        bit acked;
        waitSoftRelease(ok);
        if (!ok) return;
        report_algorithm_status    = status;
        report_response_statistics = stats;
        acked = 1'b0;
        for (int i = 0; i < 50 && !acked; i++) begin
            @(negedge clock);
            if (report_algorithm_status_ack) acked = 1'b1;
        end
        if (!acked) timeoutFail("ackWait");
        repeat (2) @(posedge clock);
        #1;
        report_algorithm_status    = '0;
        report_response_statistics = '0;
        waitIdle("drainToIdle");
    endtask

    task automatic applyStimulus(input logic [63:0] status, input logic [63:0] stats,
                                 input logic expOverflow);
        pushSoft();
        pushReport(status, stats, expOverflow);
        pulseRequest();
        completeFlow(status, stats);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  cnt;
        bit  stayedHigh;
        bit  sawLow;

        enabled_in = 1'b1;
        #2;
        checkOutput("resetSoftRstn", soft_rstn, 1'b0);
        checkOutput("resetAck", report_algorithm_status_ack, 1'b0);
        checkOutput("resetStatus", mmio_algorithm_status, 64'h0);
        checkOutput("resetValid", mmio_status_valid, 1'b0);
        checkOutput("resetOverflow", mmio_status_overflow, 1'b0);
        checkOutput("resetTimeout", mmio_report_timeout, 1'b0);
        checkOutput("resetBusy", responder_busy, 1'b1);
        repeat (2) @(posedge clock);
        #1 rstn = 1'b1;
        waitIdle("resetToIdle");
        checkOutput("idleSoftRstn", soft_rstn, 1'b1);

        // Basic flow and host read
        applyStimulus(64'h0000_0000_0000_00A5, 64'h0000_000C_0000_0007, 1'b0);
        checkOutput("basicStatus", mmio_algorithm_status, 64'hA5);
        checkOutput("basicValid", mmio_status_valid, 1'b1);
        checkOutput("basicIdle", responder_busy, 1'b0);
        hostRead();
        checkOutput("readValid", mmio_status_valid, 1'b0);
        checkOutput("readStatusKept", mmio_algorithm_status, 64'hA5);
        checkOutput("readStatsKept", mmio_response_statistics, 64'h0000_000C_0000_0007);

        // Overflow: two reports with no read in between
        applyStimulus(64'h1, 64'h0000_0001_0000_0002, 1'b0);
        applyStimulus(64'h2, 64'h0000_0003_0000_0004, 1'b1);
        checkOutput("ovfStatus", mmio_algorithm_status, 64'h2);
        checkOutput("ovfValid", mmio_status_valid, 1'b1);
        checkOutput("ovfFlag", mmio_status_overflow, 1'b1);
        hostRead();
        checkOutput("ovfReadValid", mmio_status_valid, 1'b0);
        checkOutput("ovfReadFlag", mmio_status_overflow, 1'b0);
        checkOutput("ovfReadStatus", mmio_algorithm_status, 64'h2);

        // Timeout: request with no report
        pushSoft();
        expQ.push_back('{kind: EV_TIMEOUT, status: '0, stats: '0, overflow: 1'b0, value: TIMEOUT_CYCLES});
        pulseRequest();
        sawLow = 1'b0;
        for (int i = 0; i < 100 && !sawLow; i++) begin
            @(negedge clock);
            if (mmio_report_timeout) sawLow = 1'b1;
        end
        if (!sawLow) timeoutFail("timeoutFlag");
        checkOutput("timeoutIdle", responder_busy, 1'b0);
        checkOutput("timeoutNoCapture", mmio_status_valid, 1'b0);
        hostRead();
        checkOutput("timeoutReadClear", mmio_report_timeout, 1'b0);

        // Enable gating
        @(posedge clock); #1 enabled_in = 1'b0;
        pulseRequest();
        stayedHigh = 1'b1;
        repeat (20) begin
            @(negedge clock);
            if (!soft_rstn) stayedHigh = 1'b0;
        end
        checkOutput("gatedNoSoftReset", stayedHigh, 1'b1);
        pushSoft();
        pushReport(64'h3C, 64'h0000_0005_0000_0006, 1'b0);
        @(posedge clock); #1 enabled_in = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            cnt++;
            if (!soft_rstn) break;
        end
        checkOutput("enableToSoftReset", cnt, 2);
        completeFlow(64'h3C, 64'h0000_0005_0000_0006);
        checkOutput("gatedStatus", mmio_algorithm_status, 64'h3C);

        // Asynchronous reset in the middle of a soft reset (count 3)
        pulseRequest();
        sawLow = 1'b0;
        for (int i = 0; i < 20 && !sawLow; i++) begin
            @(posedge clock); #1;
            if (!soft_rstn) sawLow = 1'b1;
        end
        if (!sawLow) timeoutFail("midResetSoftLow");
        repeat (4) @(posedge clock);
        #1 rstn = 1'b0;
        #1;
        checkOutput("asyncSoftRstn", soft_rstn, 1'b0);
        checkOutput("asyncStatus", mmio_algorithm_status, 64'h0);
        checkOutput("asyncStats", mmio_response_statistics, 64'h0);
        checkOutput("asyncValid", mmio_status_valid, 1'b0);
        checkOutput("asyncOverflow", mmio_status_overflow, 1'b0);
        checkOutput("asyncTimeout", mmio_report_timeout, 1'b0);
        checkOutput("asyncBusy", responder_busy, 1'b1);
        @(posedge clock); #1 rstn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            cnt++;
            if (!responder_busy) break;
        end
        checkOutput("releaseToIdleCycles", cnt, 2);
        checkOutput("releaseSoftRstn", soft_rstn, 1'b1);
        stayedHigh = 1'b1;
        repeat (15) begin
            @(negedge clock);
            if (!soft_rstn) stayedHigh = 1'b0;
        end
        checkOutput("pendingDiscarded", stayedHigh, 1'b1);

        checkOutput("scoreboardEmpty", expQ.size(), 0);
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/done_responder.md
Name: done_responder

Overview:
- Host-facing counterpart of the AFU done controller.
- Responds to the done controller's soft-reset request (reset_done low pulse) by driving a timed soft_rstn pulse.
- Captures the algorithm status and response statistics the done controller then presents, and returns report_algorithm_status_ack.
- Holds the captured report in MMIO-readable registers until the host reads it. Sits between the done controller and the MMIO register block in the AFU top.

Parameters:
- SOFT_RESET_CYCLES, 8, cycles soft_rstn is held low per request (legal range 1..255).
- REPORT_TIMEOUT_CYCLES, 1024, maximum cycles to wait for a nonzero report after soft reset release; 0 disables the timeout.

Ports:
- clock  in  1  AFU clock
- rstn  in  1  asynchronous active-low reset
- enabled_in  in  1  AFU enable; registered internally before use
- reset_done  in  1  from done controller; a 1→0 transition is a soft-reset request
- report_algorithm_status  in  64 [0:63]  from done controller; nonzero means a report is presented
- report_response_statistics  in  ResponseStatistcsInterface  statistics accompanying the report
- mmio_status_read  in  1  one-cycle pulse: host has read mmio_algorithm_status
- soft_rstn  out  1  active-low soft reset to done controller and datapath
- report_algorithm_status_ack  out  1  one-cycle ack to done controller
- mmio_algorithm_status  out  64 [0:63]  captured status
- mmio_response_statistics  out  ResponseStatistcsInterface  captured statistics
- mmio_status_valid  out  1  captured report not yet read by host
- mmio_status_overflow  out  1  sticky: a report was overwritten before the host read it
- mmio_report_timeout  out  1  sticky: no report arrived within REPORT_TIMEOUT_CYCLES
- responder_busy  out  1  high in any state other than RSP_IDLE

Behaviour:
- Reset values (rstn=0): state RSP_RESET, soft_rstn=0, ack=0, all mmio_* outputs=0, responder_busy=1, counters=0, registered enabled=0, reset_done edge register=1.
- Sampling: reset_done and enabled_in are registered once. A request is registered reset_done=0 while its previous sample was 1.
- The state register advances only when registered enabled=1. The request edge is latched into a pending flag so it is not lost while disabled. The pending flag clears on entry to RSP_SOFT_RESET.
- RSP_RESET → RSP_IDLE: unconditional. soft_rstn goes to 1 on this transition.
- RSP_IDLE → RSP_SOFT_RESET when the request is pending.
- RSP_SOFT_RESET: soft_rstn=0 and a counter loads SOFT_RESET_CYCLES-1. The counter decrements every cycle. At count 0, go to RSP_WAIT_REPORT; soft_rstn=1 from that cycle. soft_rstn is low for exactly SOFT_RESET_CYCLES cycles.
- RSP_WAIT_REPORT:
  - A nonzero report_algorithm_status moves to RSP_ACK and captures status and statistics into the mmio_* registers the same cycle. mmio_status_valid is set.
  - If mmio_status_valid was already 1 at capture, mmio_status_overflow is set. The new report overwrites the old one.
  - Timeout counter: if it reaches REPORT_TIMEOUT_CYCLES (nonzero parameter), set mmio_report_timeout and go to RSP_IDLE.
- RSP_ACK: report_algorithm_status_ack=1 for exactly one cycle, then RSP_DRAIN.
- RSP_DRAIN: wait until report_algorithm_status==0, then RSP_IDLE. This prevents double capture, because the done controller clears its report two cycles after the ack.
- A request arriving during RSP_WAIT_REPORT, RSP_ACK or RSP_DRAIN stays pending and is serviced from RSP_IDLE.
- mmio_status_read:
  - Clears mmio_status_valid, mmio_status_overflow and mmio_report_timeout on the next edge.
  - mmio_algorithm_status and mmio_response_statistics are retained.
  - If a read and a capture occur in the same cycle, the capture wins: valid=1, and overflow is not set by that capture.
- Reset mid-operation: rstn assertion returns all outputs to reset values immediately (asynchronous). Pending requests are discarded.
- An all-zero algorithm status can never be captured. Nonzero final status is required of the algorithm.

Decomposition:
- In AFU_PKG: responder_state enum (RSP_RESET, RSP_IDLE, RSP_SOFT_RESET, RSP_WAIT_REPORT, RSP_ACK, RSP_DRAIN), alongside done_state.
- In AFU_PKG: default constants SOFT_RESET_CYCLES_DEFAULT and REPORT_TIMEOUT_CYCLES_DEFAULT.
- ResponseStatistcsInterface is reused unchanged.
- One sub-module: done_report_capture, which holds the capture registers, the valid/overflow/timeout sticky bits and the read-clear logic. The state machine and counters stay in the top module.

Test Plan:
- Basic flow: enabled_in=1, pulse reset_done low 1 cycle, then present status 64'h0000_0000_0000_00A5 after soft_rstn rises → soft_rstn low 8 cycles; ack one cycle; mmio_algorithm_status=64'hA5, valid=1; returns to RSP_IDLE after status returns to 0.
- Host read: after the basic flow, pulse mmio_status_read → valid=0 next cycle; status still 64'hA5.
- Overflow: two complete flows (status 64'h1, then 64'h2) with no read between them → mmio_algorithm_status=64'h2, valid=1, overflow=1; a read clears both.
- Timeout: REPORT_TIMEOUT_CYCLES=16, request with no report → mmio_report_timeout=1 sixteen cycles after soft_rstn release; FSM in RSP_IDLE; ack never asserted.
- Enable gating: request pulse while enabled_in=0 → no soft reset; raise enabled_in after 20 cycles → soft_rstn low 8 cycles starting 2 cycles later.
- Async reset during RSP_SOFT_RESET: drop rstn at count 3 → soft_rstn=0, all mmio_* outputs=0 immediately; after release, FSM reaches RSP_IDLE in 1 enabled cycle and soft_rstn=1.
